riscv_uart_tx: RTL

//  Memory-mapped UART transmitter: the outbound counterpart of the UART programmer's receive path.

---
 rtl/riscv_uart_tx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_uart_tx.sv
// riscv_uart_tx: memory-mapped UART transmitter.
// Bytes written by the io bridge are queued in a small FIFO and serialized
// 8N1, LSB first, on tx. Software reads the FIFO level and flags through status.
// Optional feature macro: UART_TX_PARITY_EN inserts an even parity bit (8E1).
module riscv_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        ovf_clr,
    output logic        tx,
    output logic [31:0] status,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [NW-1:0] count_q;
    logic [NW-1:0] count_d;
    logic          ovf_q;
    logic          ovf_d;

    state_t        state_q;
    logic [CW-1:0] baudCnt_q;
    logic [2:0]    bitIdx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    logic          pop;
    logic          push;
    logic          drop;
    logic          baudDone;
    logic [7:0]    headByte;
    logic [7:0]    countSat;
    logic          fifoFull;
    logic          fifoEmpty;

    assign headByte  = mem_q[rdPtr_q];
    assign baudDone  = (baudCnt_q == BAUD_LAST);
    assign fifoFull  = (count_q == DEPTH_N);
    assign fifoEmpty = (count_q == '0);

    // FIFO handshake: a full FIFO still takes a write when the head leaves in the same cycle
    always_comb begin
        pop     = (state_q == IDLE) && !fifoEmpty;
        push    = wr_en && ((count_q < DEPTH_N) || pop);
        drop    = wr_en && !push;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + NW'(1);
        end else if (pop && !push) begin
            count_d = count_q - NW'(1);
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO pointers, fill level and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= wr_data;
        end
    end

    // Serializer: start bit, eight data bits LSB first, optional parity, stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q      <= 1'b1;
                    baudCnt_q <= '0;
                    if (pop) begin
                        shift_q <= headByte;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^headByte;
`endif
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baudDone) begin
                        baudCnt_q <= '0;
                        bitIdx_q  <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (baudDone) begin
                        baudCnt_q <= '0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baudDone) begin
                        baudCnt_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= STOP;
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baudDone) begin
                        baudCnt_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                default: begin
                    baudCnt_q <= '0;
                    tx_q      <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Status count field is 8 bits wide; deep FIFOs saturate it at 255
    generate
        if (NW > 8) begin : g_countSat
            assign countSat = (count_q > NW'(255)) ? 8'hFF : count_q[7:0];
        end else begin : g_countPad
            assign countSat = 8'(count_q);
        end
    endgenerate

    assign tx     = tx_q;
    assign busy   = (state_q != IDLE) || !fifoEmpty;
    assign status = {20'b0, ovf_q, busy, fifoFull, fifoEmpty, countSat};

endmodule
